// File: rtl/ram_fifo_if.sv
// Push/pop and RAM-side bundle for ram_fifo_ctrl. FIFO_ERR_FLAGS_EN adds the
// sticky overflow/underflow flags.
interface ram_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    // Requester plus RAM side: drives requests and the RAM read data.
    modport master (
`ifdef FIFO_ERR_FLAGS_EN
        input  overflow, underflow,
`endif
        output push, push_data, pop, ram_q,
        input  pop_data, pop_valid, full, empty, count,
        input  ram_we, ram_wdata, ram_waddr, ram_raddr
    );

    // The FIFO controller.
    modport slave (
`ifdef FIFO_ERR_FLAGS_EN
        output overflow, underflow,
`endif
        input  push, push_data, pop, ram_q,
        output pop_data, pop_valid, full, empty, count,
        output ram_we, ram_wdata, ram_waddr, ram_raddr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-address RAM with 1-cycle registered read.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    ram_fifo_if.slave  bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  pop_valid_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign push_ok = bus.push & ~full_c;
    assign pop_ok  = bus.pop  & ~empty_c;

    // RAM controls follow the pointers directly; pop data comes straight off q.
    assign bus.ram_we    = push_ok;
    assign bus.ram_waddr = wr_ptr;
    assign bus.ram_wdata = bus.push_data;
    assign bus.ram_raddr = rd_ptr;
    assign bus.pop_data  = bus.ram_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.count     = count_q;

    // Pointers wrap naturally at DEPTH since they are exactly ADDR_WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= pop_ok;
            if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky until reset: record any request rejected for lack of room/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.push & full_c);
            underflow_q <= underflow_q | (bus.pop  & empty_c);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a RAM model, reference queue and pop-data scoreboard.
module tb_ram_fifo_ctrl;
    logic clk;
    logic rst;

    ram_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64x8 RAM with registered read and write-through bypass.
    logic [7:0] mem [64];
    always_ff @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_q <= (bus.ram_we && bus.ram_waddr == bus.ram_raddr) ? bus.ram_wdata
                                                                   : mem[bus.ram_raddr];
    end

    int         checks;
    int         failures;
    logic [7:0] mdl [$];
    logic [7:0] exp_q [$];
    int         mwr;
    int         mrd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1; checks pre-edge outputs.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        logic wok;
        logic pok;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        wok = p && (mdl.size() != 64);
        pok = q && (mdl.size() != 0);
        @(negedge clk);
        chk("ram_we",    32'(bus.ram_we),    32'(wok));
        chk("count",     32'(bus.count),     32'(mdl.size()));
        chk("full",      32'(bus.full),      32'(mdl.size() == 64));
        chk("empty",     32'(bus.empty),     32'(mdl.size() == 0));
        chk("ram_raddr", 32'(bus.ram_raddr), 32'(mrd));
        if (wok) begin
            chk("ram_waddr", 32'(bus.ram_waddr), 32'(mwr));
            chk("ram_wdata", 32'(bus.ram_wdata), 32'(d));
        end
        if (pok) begin
            exp_q.push_back(mdl.pop_front());
            mrd = (mrd + 1) % 64;
        end
        if (wok) begin
            mdl.push_back(d);
            mwr = (mwr + 1) % 64;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mwr      = 0;
        mrd      = 0;
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = 8'h00;

        // Scoreboard monitor: every presented pop word must match the oldest expected.
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.pop_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop_valid", 32'(bus.pop_valid), 32'd0);
                    end else begin
                        chk("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        #1;
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_empty",     32'(bus.empty),     32'd1);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill 0x00..0x3F, then a dropped 65th push.
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd64);
        step(1'b1, 8'hAA, 1'b0);
        chk("over_count", 32'(bus.count), 32'd64);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(bus.overflow), 32'd1);
`endif

        // Drain 64 back-to-back pops.
        drain(64);
        step(1'b0, 8'h00, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);

        // Simultaneous push+pop at count=1.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h55, 1'b1);
        chk("pp1_count",     32'(bus.count),     32'd1);
        chk("pp1_pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("pp1_pop_data",  32'(bus.pop_data),  32'h11);
        drain(1);

        // Simultaneous push+pop at full: push dropped.
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i) ^ 8'h80, 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("ppfull_count", 32'(bus.count), 32'd63);
        drain(63);

        // 100 words streamed with occupancy at most 3, wrapping both pointers.
        for (int i = 0; i < 103; i++) step(i < 100, 8'(i * 3 + 1), i >= 3);
        step(1'b0, 8'h00, 1'b0);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Pop while empty is dropped.
        step(1'b0, 8'h00, 1'b1);
        chk("empty_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("empty_pop_count", 32'(bus.count),     32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_set",   32'(bus.underflow), 32'd1);
        chk("overflow_sticky", 32'(bus.overflow),  32'd1);
`endif

        // Reset mid-cycle with a pop in flight.
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h23, 1'b1);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_count",     32'(bus.count),     32'd0);
        chk("mrst_empty",     32'(bus.empty),     32'd1);
        chk("mrst_full",      32'(bus.full),      32'd0);
        chk("mrst_pop_valid", 32'(bus.pop_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("mrst_overflow",  32'(bus.overflow),  32'd0);
        chk("mrst_underflow", 32'(bus.underflow), 32'd0);
`endif
        exp_q.delete();
        mdl.delete();
        mwr = 0;
        mrd = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Post-reset traffic restarts from address 0.
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'hA5, 1'b1);
        drain(1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
